// File: rtl/ibutterfly_2.sv
// ibutterfly_2: two-point inverse butterfly with a shared add/subtract datapath and a conjugate-symmetry check
module ibutterfly_2 #(
  parameter int N = 4,
  localparam int W = 2 ** N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] xr1,
  input  logic [W-1:0] xi1,
  input  logic [W-1:0] xr2,
  input  logic [W-1:0] xi2,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         err
);
  typedef enum logic [1:0] {IDLE, CALC_A, CALC_B, HOLD} state_t;
  state_t state, state_nx;
  logic up;
  logic [W-1:0] r1, i1, r2, i2, half;
  logic [W:0] op_x, op_y, sum;
  logic bad;
  assign in_ready  = up && state == IDLE;
  assign out_valid = state == HOLD;
  // next state: IDLE waits for a handshake, HOLD waits for the consumer
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (in_valid && in_ready) ? CALC_A : IDLE;
      CALC_A:  state_nx = CALC_B;
      CALC_B:  state_nx = HOLD;
      default: state_nx = out_ready ? IDLE : HOLD;
    endcase
  end
  // one W+1-bit adder: xr1+xr2 in CALC_A, xi2-xi1 in CALC_B; halving is an arithmetic shift (floor)
  always_comb begin
    op_x = (state == CALC_B) ? {i2[W-1], i2} : {r1[W-1], r1};
    op_y = (state == CALC_B) ? {i1[W-1], i1} : {r2[W-1], r2};
    sum  = (state == CALC_B) ? op_x - op_y : op_x + op_y;
    half = W'(sum >> 1);
    bad  = (r1 != r2) || ((i1 + i2) != '0);
  end
  // state, captured operands, results and sticky error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      up    <= 1'b0;
      {r1, i1, r2, i2} <= '0;
      a     <= '0;
      b     <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      up    <= 1'b1;
      if (in_valid && in_ready) {r1, i1, r2, i2} <= {xr1, xi1, xr2, xi2};
      if (state == CALC_A) a <= half;
      if (state == CALC_B) b <= half;
      if (state == CALC_B) err <= err | bad;
    end
  end
endmodule
